// File: rtl/demux_1to16_reg.sv
// Registered 1-to-16 demultiplexer with one-hot write strobe and a
// 16-cycle sequential clear walked LSB-first by a small two-state FSM.
module demux_1to16_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  s,
  input  logic        d,
  input  logic        clr,
  output logic [15:0] z,
  output logic [15:0] strb,
  output logic        busy,
  output logic        dbg_state,
  output logic [3:0]  dbg_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic [15:0] r_z;
  logic [15:0] w_next_z;
  logic [15:0] r_strb;
  logic [15:0] w_next_strb;
  logic        r_busy;
  logic        w_next_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_z     <= 16'h0000;
      r_strb  <= 16'h0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_z     <= w_next_z;
      r_strb  <= w_next_strb;
      r_busy  <= w_next_busy;
    end
  end

  // s and d are only looked at when a write is actually taken, so X on
  // them while we=0 cannot leak into state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_z     = r_z;
    w_next_strb  = 16'h0000;
    w_next_busy  = r_busy;
    case (r_state)
      IDLE: begin
        if (clr) begin
          w_next_state = CLEAR;
          w_next_cnt   = 4'd0;
          w_next_busy  = 1'b1;
        end else if (we) begin
          w_next_z[s]    = d;
          w_next_strb[s] = 1'b1;
        end
      end
      CLEAR: begin
        w_next_z[r_cnt]    = 1'b0;
        w_next_strb[r_cnt] = 1'b1;
        w_next_cnt         = r_cnt + 4'd1;
        // Last destination: counter wraps to 0 on its own.
        if (r_cnt == 4'd15) begin
          w_next_state = IDLE;
          w_next_busy  = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_busy  = 1'b0;
      end
    endcase
  end

  assign z         = r_z;
  assign strb      = r_strb;
  assign busy      = r_busy;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_demux_1to16_reg.sv
// Directed plus randomized bench for demux_1to16_reg, checked against a
// behavioural model of the write/clear rules using immediate assertions.
module tb_demux_1to16_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  s;
  logic        d;
  logic        clr;
  logic [15:0] z;
  logic [15:0] strb;
  logic        busy;
  logic        dbg_state;
  logic [3:0]  dbg_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: destination bits, last strobe, and the index of the
  // next destination to clear (-1 while no clear is running).
  logic [15:0] m_z;
  logic [15:0] m_strb;
  int          m_clr_idx;

  demux_1to16_reg dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .s         (s),
    .d         (d),
    .clr       (clr),
    .z         (z),
    .strb      (strb),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic m_busy;
    m_busy = (m_clr_idx >= 0);
    chk({tag, "_z"}, z, m_z);
    chk({tag, "_strb"}, strb, m_strb);
    chk({tag, "_busy"}, {15'd0, busy}, {15'd0, m_busy});
    n_assert++;
    assert ($onehot0(strb)) else begin
      n_fail++;
      $error("FAIL %s_onehot observed=%h expected=at most one bit", tag, strb);
    end
  endtask

  task automatic model_edge(input logic we_i, input logic [3:0] s_i,
                            input logic d_i, input logic clr_i);
    if (m_clr_idx >= 0) begin
      m_z[m_clr_idx] = 1'b0;
      m_strb = 16'h0000;
      m_strb[m_clr_idx] = 1'b1;
      m_clr_idx++;
      if (m_clr_idx == 16) m_clr_idx = -1;
    end else if (clr_i) begin
      m_clr_idx = 0;
      m_strb = 16'h0000;
    end else if (we_i) begin
      m_z[s_i] = d_i;
      m_strb = 16'h0000;
      m_strb[s_i] = 1'b1;
    end else begin
      m_strb = 16'h0000;
    end
  endtask

  // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
  task automatic step(input logic we_i, input logic [3:0] s_i, input logic d_i,
                      input logic clr_i, input string tag);
    we = we_i; s = s_i; d = d_i; clr = clr_i;
    @(posedge clk);
    model_edge(we_i, s_i, d_i, clr_i);
    #1;
    check_all(tag);
  endtask

  // Reset is raised between edges with live inputs; outputs must clear at once.
  task automatic do_reset(input string tag);
    we = 1'b1; s = 4'd9; d = 1'b1; clr = 1'b1;
    reset = 1'b1;
    m_z = 16'h0000; m_strb = 16'h0000; m_clr_idx = -1;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    we = 1'b0; clr = 1'b0;
    reset = 1'b0;
  endtask

  logic [3:0] wr_s [6];
  logic       wr_d [6];

  initial begin
    reset = 1'b0; we = 1'b0; s = 4'd0; d = 1'b0; clr = 1'b0;
    m_z = 16'h0000; m_strb = 16'h0000; m_clr_idx = -1;
    #1;
    do_reset("reset_init");

    // Single write to destination 2, then strobe drops; X select ignored.
    step(1'b1, 4'd2, 1'b1, 1'b0, "wr_s2");
    chk("wr_s2_const_z", z, 16'h0004);
    chk("wr_s2_const_strb", strb, 16'h0004);
    step(1'b0, 4'bxxxx, 1'bx, 1'b0, "idle_x");
    chk("idle_x_strb", strb, 16'h0000);

    // Write pattern giving 8428.
    do_reset("reset_pat");
    wr_s = '{4'd3, 4'd7, 4'd5, 4'd15, 4'd10, 4'd7};
    wr_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) step(1'b1, wr_s[i], wr_d[i], 1'b0, "pat");
    chk("pat_const_z", z, 16'h8428);

    // Repeated writes to one destination keep the strobe high.
    step(1'b1, 4'd6, 1'b1, 1'b0, "rep0");
    step(1'b1, 4'd6, 1'b0, 1'b0, "rep1");
    step(1'b1, 4'd6, 1'b1, 1'b0, "rep2");

    // Fill to FFFF, then clr with a simultaneous write that must be ignored.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1, 1'b0, "fill");
    chk("fill_const_z", z, 16'hFFFF);
    step(1'b1, 4'd0, 1'b0, 1'b1, "clr_we");
    chk("clr_we_const_z", z, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, "clr_walk");
      chk("clr_walk_const_strb", strb, 16'h0001 << i);
    end
    chk("clr_done_const_z", z, 16'h0000);
    chk("clr_done_const_busy", {15'd0, busy}, 16'h0000);

    // Abort a clear with reset after 5 cycles.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b1, 1'b0, "fill2");
    step(1'b0, 4'd0, 1'b0, 1'b1, "clr2_start");
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b0, 1'b0, "clr2_walk");
    do_reset("reset_mid_clear");
    step(1'b0, 4'd0, 1'b0, 1'b0, "post_abort_idle");
    step(1'b1, 4'd15, 1'b1, 1'b0, "post_abort_wr");
    chk("post_abort_const_z", z, 16'h8000);

    // Writes and clr during CLEAR are ignored; length stays 16.
    step(1'b0, 4'd0, 1'b0, 1'b1, "clr3_start");
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'd1, 1'b1, (i == 3 || i == 9), "clr3_walk");
    chk("clr3_done_const_busy", {15'd0, busy}, 16'h0000);
    chk("clr3_done_const_z", z, 16'h0000);
    step(1'b0, 4'd0, 1'b0, 1'b0, "clr3_after");

    // clr held high restarts immediately once IDLE is reached.
    step(1'b0, 4'd0, 1'b0, 1'b1, "clr4_start");
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 1'b0, 1'b1, "clr4_held");
    step(1'b0, 4'd0, 1'b0, 1'b1, "clr4_restart");
    chk("clr4_restart_const_busy", {15'd0, busy}, 16'h0001);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 1'b0, 1'b0, "clr4_walk");

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to16_reg.md
DEMUX_1TO16_REG -- requirements
Module: demux_1to16_reg

Interface
REQ-001 The block SHALL have no parameters; width (16 destinations, 4-bit select) is fixed.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 we  input  1  SHALL be the write enable; when high, d is routed to the destination chosen by s.
REQ-005 s  input  4  SHALL be the destination select; binary 0000 selects z[0], 1111 selects z[15].
REQ-006 d  input  1  SHALL be the data bit to be written.
REQ-007 clr  input  1  SHALL be the request to start a sequential clear of all 16 destinations.
REQ-008 z  output  16  SHALL hold the registered value of each destination; bit n corresponds to select value n.
REQ-009 strb  output  16  SHALL be a registered one-hot write strobe; bit n is high for one cycle after destination n is written.
REQ-010 busy  output  1  SHALL be a registered flag, high while a clear sequence is in progress.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and CLEAR, plus a 4-bit clear counter cnt.
REQ-012 In IDLE with clr=0 and we=1, on the clock edge z[s] SHALL take d, all other z bits SHALL hold, and strb SHALL become one-hot(s).
REQ-013 In IDLE with clr=0 and we=0, z SHALL hold, strb SHALL become 0, and s/d SHALL have no effect, including X values.
REQ-014 Write latency SHALL be one cycle: z and strb reflect a write at the first rising edge where we=1 is sampled.
REQ-015 Repeated writes to the same destination on consecutive cycles SHALL each update z[s]; strb SHALL stay high for every such cycle.
REQ-016 In IDLE with clr=1, the FSM SHALL enter CLEAR and set busy=1 and cnt=0; a simultaneous we=1 SHALL be ignored: no z change, strb=0.
REQ-017 In CLEAR, each cycle SHALL clear z[cnt] to 0, set strb to one-hot(cnt), and increment cnt.
REQ-018 When cnt=15 in CLEAR, that edge SHALL clear z[15], return the FSM to IDLE, and drop busy; cnt SHALL wrap to 0.
REQ-019 A clear sequence SHALL take exactly 16 cycles with busy high; strb SHALL walk bit 0 through bit 15 in order.
REQ-020 In CLEAR, we and clr SHALL be ignored; a clr asserted during CLEAR SHALL NOT restart or extend the sequence.
REQ-021 After CLEAR returns to IDLE, a clr still held high SHALL start a new sequence on the next edge.
REQ-022 strb SHALL never have more than one bit set.

Reset
REQ-023 On reset assertion, without waiting for a clock edge: z=16'h0000, strb=16'h0000, busy=0, FSM=IDLE, cnt=0.
REQ-024 Reset asserted during CLEAR SHALL abort the sequence immediately; after release, the block SHALL be in IDLE with no pending clear.
REQ-025 Whenever reset is high, inputs SHALL be ignored.

Verification
REQ-026 Reset, then we=1, s=0010, d=1 for one cycle -> z=16'h0004, strb=16'h0004 for one cycle, then strb=0.
REQ-027 Writes of d=1 to s=0011, 0111, 0101, 1111, 1010, then d=0 to s=0111 -> z=16'h8428, each strb the matching one-hot.
REQ-028 With z=16'hFFFF, pulse clr=1 together with we=1, s=0000, d=0 -> write ignored.
REQ-029 Continuation of REQ-028 -> busy high 16 cycles, strb walks 0001..8000, z clears LSB-first to 0000, busy drops.
REQ-030 Assert reset mid-CLEAR after 5 cycles -> z=0, busy=0 asynchronously; after release, we=1, s=1111, d=1 -> z=16'h8000.
REQ-031 During CLEAR, drive we=1, s=0001, d=1 and re-pulse clr -> no write, sequence still ends after exactly 16 cycles.
